// File: rtl/dvi_video_prep_pkg.sv
// Shared types and constants for the DVI video preparation block:
// frame-lock FSM states, line counter sizing and the exact 6->8 bit colour scaler.
package dvi_video_prep_pkg;

  localparam int LINE_CNT_W = 10;
  localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = {LINE_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    VERIFY,
    LOCKED
  } lock_state_e;

  // Exact floor(c*255/63); 63*255 = 16065 fits in 14 bits.
  function automatic logic [7:0] scale_6to8(input logic [5:0] c);
    logic [13:0] prod;
    prod = 14'(c) * 14'd255;
    return 8'(prod / 14'd63);
  endfunction

endpackage

// File: rtl/dvi_video_prep_if.sv
// Video bundle between the VIC-II side and the DVI encoder side.
// master drives raw colour/timing and receives prepared video; slave is dvi_video_prep.
interface dvi_video_prep_if;
  import dvi_video_prep_pkg::*;

  logic [5:0]            red_i;
  logic [5:0]            green_i;
  logic [5:0]            blue_i;
  logic                  hsync_i;
  logic                  vsync_i;
  logic                  active_i;
  logic [7:0]            red_o;
  logic [7:0]            green_o;
  logic [7:0]            blue_o;
  logic                  hsync_o;
  logic                  vsync_o;
  logic                  de_o;
  logic                  frame_locked_o;
  logic [LINE_CNT_W-1:0] lines_o;

  modport master (
    output red_i, green_i, blue_i, hsync_i, vsync_i, active_i,
    input  red_o, green_o, blue_o, hsync_o, vsync_o, de_o, frame_locked_o, lines_o
  );

  modport slave (
    input  red_i, green_i, blue_i, hsync_i, vsync_i, active_i,
    output red_o, green_o, blue_o, hsync_o, vsync_o, de_o, frame_locked_o, lines_o
  );

endinterface

// File: rtl/dvi_video_prep_frame_lock_fsm.sv
// Frame-lock tracker: counts lines per frame and asserts lock after two equal frames.
// Only compiled when DVI_FRAME_LOCK_EN is defined.
`ifdef DVI_FRAME_LOCK_EN
module frame_lock_fsm
  import dvi_video_prep_pkg::*;
(
  input  logic                  clk_dot4x,
  input  logic                  rst,
  input  logic                  hsync_n,
  input  logic                  vsync_n,
  output logic                  frame_locked,
  output logic [LINE_CNT_W-1:0] lines
);

  localparam logic [LINE_CNT_W-1:0] CNT_ONE = LINE_CNT_W'(1);

  lock_state_e           state, state_nxt;
  logic                  hs_hist, vs_hist;
  logic                  hs_edge, vs_edge;
  logic [LINE_CNT_W-1:0] line_cnt, ref_lines;
  logic                  cnt_bad, cnt_match;
  logic                  ref_load, ref_clear;
  logic                  locked_q;

  assign hs_edge   = hsync_n & ~hs_hist;
  assign vs_edge   = vsync_n & ~vs_hist;
  assign cnt_bad   = (line_cnt == '0) || (line_cnt == LINE_CNT_MAX);
  assign cnt_match = (line_cnt == ref_lines);

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      hs_hist <= 1'b0;
      vs_hist <= 1'b0;
    end else begin
      hs_hist <= hsync_n;
      vs_hist <= vsync_n;
    end
  end

  // A line edge coinciding with the frame edge belongs to the new frame.
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst)
      line_cnt <= '0;
    else if (vs_edge)
      line_cnt <= hs_edge ? CNT_ONE : '0;
    else if (hs_edge && (line_cnt != LINE_CNT_MAX))
      line_cnt <= line_cnt + CNT_ONE;
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst)
      state <= SEARCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vs_edge) begin
      case (state)
        SEARCH:  state_nxt = MEASURE;
        MEASURE: state_nxt = cnt_bad ? SEARCH : VERIFY;
        VERIFY:  state_nxt = cnt_bad ? SEARCH : (cnt_match ? LOCKED : VERIFY);
        LOCKED:  state_nxt = cnt_bad ? SEARCH : (cnt_match ? LOCKED : VERIFY);
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    ref_load  = 1'b0;
    ref_clear = 1'b0;
    if (vs_edge && (state != SEARCH)) begin
      if (cnt_bad)
        ref_clear = 1'b1;
      else if ((state == MEASURE) || !cnt_match)
        ref_load = 1'b1;
    end
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      ref_lines <= '0;
      locked_q  <= 1'b0;
    end else begin
      if (ref_clear)
        ref_lines <= '0;
      else if (ref_load)
        ref_lines <= line_cnt;
      locked_q <= (state_nxt == LOCKED);
    end
  end

  assign frame_locked = locked_q;
  assign lines        = locked_q ? ref_lines : '0;

endmodule
`endif

// File: rtl/dvi_video_prep.sv
// Scales 6-bit VIC-II colour to 8 bits and aligns it with the syncs through a 2-stage pipeline.
// Define DVI_FRAME_LOCK_EN to gate de_o with a line-count frame lock; otherwise de_o follows active.
module dvi_video_prep
  import dvi_video_prep_pkg::*;
#(
  parameter bit HSYNC_ACT_LOW = 1'b0,
  parameter bit VSYNC_ACT_LOW = 1'b0
) (
  input logic             clk_dot4x,
  input logic             rst,
  dvi_video_prep_if.slave vid
);

  logic                  hsync_n, vsync_n;
  logic [7:0]            red_s1, green_s1, blue_s1;
  logic [7:0]            red_s2, green_s2, blue_s2;
  logic                  hs_s1, vs_s1, act_s1;
  logic                  hs_s2, vs_s2, act_s2;
  logic                  frame_locked;
  logic [LINE_CNT_W-1:0] lines;
  logic                  de;

  assign hsync_n = vid.hsync_i ^ HSYNC_ACT_LOW;
  assign vsync_n = vid.vsync_i ^ VSYNC_ACT_LOW;

  // Syncs travel normalised so that reset clears them to the deasserted level.
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      red_s1   <= '0;
      green_s1 <= '0;
      blue_s1  <= '0;
      hs_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      act_s1   <= 1'b0;
      red_s2   <= '0;
      green_s2 <= '0;
      blue_s2  <= '0;
      hs_s2    <= 1'b0;
      vs_s2    <= 1'b0;
      act_s2   <= 1'b0;
    end else begin
      red_s1   <= scale_6to8(vid.red_i);
      green_s1 <= scale_6to8(vid.green_i);
      blue_s1  <= scale_6to8(vid.blue_i);
      hs_s1    <= hsync_n;
      vs_s1    <= vsync_n;
      act_s1   <= vid.active_i;
      red_s2   <= red_s1;
      green_s2 <= green_s1;
      blue_s2  <= blue_s1;
      hs_s2    <= hs_s1;
      vs_s2    <= vs_s1;
      act_s2   <= act_s1;
    end
  end

`ifdef DVI_FRAME_LOCK_EN
  frame_lock_fsm u_frame_lock (
    .clk_dot4x    (clk_dot4x),
    .rst          (rst),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .frame_locked (frame_locked),
    .lines        (lines)
  );
`else
  assign frame_locked = 1'b1;
  assign lines        = '0;
`endif

  // Gating against the registered lock flag drops de_o in the same cycle lock is lost.
  assign de                 = act_s2 & frame_locked;
  assign vid.de_o           = de;
  assign vid.red_o          = de ? red_s2 : 8'd0;
  assign vid.green_o        = de ? green_s2 : 8'd0;
  assign vid.blue_o         = de ? blue_s2 : 8'd0;
  assign vid.hsync_o        = hs_s2 ^ HSYNC_ACT_LOW;
  assign vid.vsync_o        = vs_s2 ^ VSYNC_ACT_LOW;
  assign vid.frame_locked_o = frame_locked;
  assign vid.lines_o        = lines;

endmodule

// File: doc/dvi_video_prep.md
DVI_VIDEO_PREP -- requirements
Module: dvi_video_prep

Interface
REQ-001 Parameter HSYNC_ACT_LOW, default 0: hsync_i is asserted when low if 1.
REQ-002 Parameter VSYNC_ACT_LOW, default 0: vsync_i is asserted when low if 1.
REQ-003 Ports: clk_dot4x in 1 pixel clock; rst in 1 reset, asynchronous, active-high.
REQ-004 Ports: red_i, green_i, blue_i in 6 each; raw colour from vicii.
REQ-005 Ports: hsync_i, vsync_i, active_i in 1 each; raw timing from vicii.
REQ-006 Ports: red_o, green_o, blue_o out 8 each; scaled colour to the DVI encoder.
REQ-007 Ports: hsync_o, vsync_o out 1 each, delayed syncs with original polarity; de_o out 1, gated data enable.
REQ-008 Ports: frame_locked_o out 1 (timing stable); lines_o out 10 (last verified lines per frame).

Function
REQ-009 Colour scaling SHALL be exact: out = floor(in*255/63), 8-bit result (0->0, 1->4, 16->64, 21->85, 63->255); bit replication is not allowed.
REQ-010 All video outputs SHALL have a fixed latency of 2 clk_dot4x cycles and stay mutually aligned.
REQ-011 Syncs SHALL be normalised internally to active-high per the parameters, then restored to input polarity on output.
REQ-012 Sync edge events are the cycles in which the normalised sync goes 0->1, detected with a 1-cycle history register.
REQ-013 Line counter: 10 bits; +1 on each hsync edge; saturates at 1023 and does not wrap.
REQ-014 Frame boundary = vsync edge. In that cycle the counter value is captured and compared, then the counter loads 0, or 1 if an hsync edge occurs in the same cycle.
REQ-015 FSM state SEARCH (reset state): go to MEASURE on the first vsync edge; no comparison is made.
REQ-016 FSM state MEASURE: at the next vsync edge, store the count in ref_lines and go to VERIFY.
REQ-017 FSM state VERIFY: at a vsync edge, if count == ref_lines go to LOCKED; otherwise store the count in ref_lines and stay in VERIFY.
REQ-018 FSM state LOCKED: at a vsync edge, if count != ref_lines store the count and go to VERIFY (this covers a PAL/NTSC switch).
REQ-019 Any frame count of 0 or 1023 SHALL force SEARCH, clearing ref_lines.
REQ-020 frame_locked_o is registered: 1 exactly while the state is LOCKED, updated the cycle after the deciding vsync edge.
REQ-021 lines_o = ref_lines while LOCKED, else 0.
REQ-022 de_o = delayed active_i AND frame_locked_o, evaluated at the output stage.
REQ-023 RGB outputs SHALL be 0 whenever de_o is 0.
REQ-024 Syncs SHALL pass through in every state.
REQ-025 Lock loss takes effect on de_o in the same output cycle that frame_locked_o falls.

Reset
REQ-026 On rst all outputs SHALL be 0, except syncs at their deasserted level (1 when the matching _ACT_LOW parameter is 1).
REQ-027 On rst the FSM goes to SEARCH, and the counter, ref_lines, pipeline and edge history all clear.
REQ-028 A reset asserted mid-frame SHALL abandon the measurement; relock needs the full SEARCH->MEASURE->VERIFY->LOCKED path (3 vsync edges minimum).

Configuration
REQ-029 Macro DVI_FRAME_LOCK_EN defined: behaviour exactly as REQ-013 to REQ-025.
REQ-030 Macro DVI_FRAME_LOCK_EN undefined: no FSM or counters are built.
REQ-031 In that case frame_locked_o is tied 1, lines_o is tied 0, de_o = delayed active_i, and latency stays 2 cycles.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (SEARCH, MEASURE, VERIFY, LOCKED), LINE_CNT_W=10 and the line-count saturation constant.
REQ-033 Sub-module frame_lock_fsm holds the edge detection, line counter, ref_lines and state.
REQ-034 The top of dvi_video_prep holds the scaling table/arithmetic and the output pipeline.

Verification
REQ-035 After reset, drive 312-line frames with active=1 everywhere: frame_locked_o rises after the 3rd vsync edge, lines_o=312, de_o follows active with 2-cycle latency.
REQ-036 Sweep every colour input 0..63: output matches floor(x*255/63) (0,4,...,64 at 16,...,255 at 63) 2 cycles later while de_o=1, and 0 while de_o=0.
REQ-037 While locked on 312, switch to 263-line frames: frame_locked_o and de_o fall after the first 263 frame; relock one frame later with lines_o=263.
REQ-038 Assert hsync and vsync edges in the same cycle: the new frame's count starts at 1 and a steady 312 frame still locks as 312.
REQ-039 Hold hsync toggling without vsync: the count sticks at 1023; at the next vsync the FSM returns to SEARCH and frame_locked_o=0.
REQ-040 Assert rst mid-frame while LOCKED: all outputs are 0 immediately (syncs deasserted) and relock needs 3 vsync edges; with HSYNC_ACT_LOW=1, hsync_o stays 1 during reset.
